// File: rtl/memory_responder.sv
// Byte-addressed big-endian data memory answering MAR/MDR/RAM_OpCode/MFC requests.
// A request is latched, held for WAIT_STATES cycles, performed in one edge, then MFC is held until release.
module memory_responder #(
    parameter int ADDR_WIDTH  = 9,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        RAM_enable,
    input  logic [5:0]  RAM_OpCode,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        MFC,
    output logic        mem_fault,
    output logic [1:0]  o_dbg_state
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CNT_W = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_next;
    logic [5:0]              r_op;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [31:0]             r_wdata;
    logic [31:0]             r_data_out;
    logic                    r_mfc;
    logic                    r_fault;

    logic                    w_latch;
    logic                    w_access;
    logic                    w_release;

    logic                    w_is_load;
    logic                    w_is_store;
    logic                    w_signed;
    logic [1:0]              w_size;
    logic                    w_bad_op;
    logic                    w_misalign;
    logic                    w_fault;
    logic                    w_we;

    logic [ADDR_WIDTH-1:0]   w_a1;
    logic [ADDR_WIDTH-1:0]   w_a2;
    logic [ADDR_WIDTH-1:0]   w_a3;
    logic [7:0]              w_b0;
    logic [7:0]              w_b1;
    logic [7:0]              w_b2;
    logic [7:0]              w_b3;
    logic [31:0]             w_rdata;

    logic [7:0]              r_mem [0:DEPTH-1];

    // Address bits above the memory size are ignored so addresses wrap.
    logic                    w_unused_addr;
    assign w_unused_addr = ^address[31:ADDR_WIDTH];

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_latch    = 1'b0;
        w_access   = 1'b0;
        w_release  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (RAM_enable) begin
                    w_latch    = 1'b1;
                    w_cnt_next = CNT_W'(WAIT_STATES);
                    w_next     = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                if (!RAM_enable) begin
                    w_next     = S_IDLE;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                    if (r_cnt <= CNT_W'(1)) begin
                        w_next = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                if (!RAM_enable) begin
                    w_next = S_IDLE;
                end else begin
                    w_access = 1'b1;
                    w_next   = S_DONE;
                end
            end
            S_DONE: begin
                if (!RAM_enable) begin
                    w_release = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_op       <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_data_out <= '0;
            r_mfc      <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_latch) begin
                r_op    <= RAM_OpCode;
                r_addr  <= address[ADDR_WIDTH-1:0];
                r_wdata <= data_in;
            end
            if (w_access) begin
                r_mfc   <= 1'b1;
                r_fault <= w_fault;
                if (w_is_load && !w_fault) begin
                    r_data_out <= w_rdata;
                end
            end else if (w_release) begin
                r_mfc   <= 1'b0;
                r_fault <= 1'b0;
            end
        end
    end

    // Opcode decode works on the latched request, never on live inputs.
    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_signed   = 1'b0;
        w_size     = SZ_BYTE;
        w_bad_op   = 1'b0;
        case (r_op)
            6'b000000: begin w_is_load  = 1'b1; w_size = SZ_WORD; end
            6'b000001: begin w_is_load  = 1'b1; w_size = SZ_BYTE; end
            6'b000010: begin w_is_load  = 1'b1; w_size = SZ_HALF; end
            6'b001001: begin w_is_load  = 1'b1; w_size = SZ_BYTE; w_signed = 1'b1; end
            6'b001010: begin w_is_load  = 1'b1; w_size = SZ_HALF; w_signed = 1'b1; end
            6'b000100: begin w_is_store = 1'b1; w_size = SZ_WORD; end
            6'b000101: begin w_is_store = 1'b1; w_size = SZ_BYTE; end
            6'b000110: begin w_is_store = 1'b1; w_size = SZ_HALF; end
            default:   begin w_bad_op   = 1'b1; end
        endcase
        w_misalign = ((w_size == SZ_WORD) && (r_addr[1:0] != 2'b00)) ||
                     ((w_size == SZ_HALF) && r_addr[0]);
        w_fault    = w_bad_op || w_misalign;
    end

    assign w_we = w_access && w_is_store && !w_fault;

    assign w_a1 = r_addr + ADDR_WIDTH'(1);
    assign w_a2 = r_addr + ADDR_WIDTH'(2);
    assign w_a3 = r_addr + ADDR_WIDTH'(3);
    assign w_b0 = r_mem[r_addr];
    assign w_b1 = r_mem[w_a1];
    assign w_b2 = r_mem[w_a2];
    assign w_b3 = r_mem[w_a3];

    always_comb begin
        w_rdata = '0;
        case (w_size)
            SZ_WORD: w_rdata = {w_b0, w_b1, w_b2, w_b3};
            SZ_HALF: w_rdata = w_signed ? {{16{w_b0[7]}}, w_b0, w_b1}
                                        : {16'h0000, w_b0, w_b1};
            default: w_rdata = w_signed ? {{24{w_b0[7]}}, w_b0}
                                        : {24'h000000, w_b0};
        endcase
    end

    // Storage is deliberately not reset; all bytes of a store land on the one ACCESS edge.
    always_ff @(posedge clk) begin
        if (w_we) begin
            case (w_size)
                SZ_WORD: begin
                    r_mem[r_addr] <= r_wdata[31:24];
                    r_mem[w_a1]   <= r_wdata[23:16];
                    r_mem[w_a2]   <= r_wdata[15:8];
                    r_mem[w_a3]   <= r_wdata[7:0];
                end
                SZ_HALF: begin
                    r_mem[r_addr] <= r_wdata[15:8];
                    r_mem[w_a1]   <= r_wdata[7:0];
                end
                default: begin
                    r_mem[r_addr] <= r_wdata[7:0];
                end
            endcase
        end
    end

    assign data_out    = r_data_out;
    assign MFC         = r_mfc;
    assign mem_fault   = r_fault;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_memory_responder.sv
// Self-checking bench for memory_responder: table of transactions plus abort, reset and handshake sequences.
module tb_memory_responder;

    localparam int AW = 9;
    localparam int WS = 2;

    localparam logic [5:0] OP_LD   = 6'b000000;
    localparam logic [5:0] OP_LDUB = 6'b000001;
    localparam logic [5:0] OP_LDUH = 6'b000010;
    localparam logic [5:0] OP_LDSB = 6'b001001;
    localparam logic [5:0] OP_LDSH = 6'b001010;
    localparam logic [5:0] OP_ST   = 6'b000100;
    localparam logic [5:0] OP_STB  = 6'b000101;
    localparam logic [5:0] OP_STH  = 6'b000110;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic        clk;
    logic        clr;
    logic        RAM_enable;
    logic [5:0]  RAM_OpCode;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        MFC;
    logic        mem_fault;
    logic [1:0]  dbg_state;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] exp_q[$];
    logic        expf_q[$];

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_fault;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs[NV];

    memory_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
        .clk        (clk),
        .clr        (clr),
        .RAM_enable (RAM_enable),
        .RAM_OpCode (RAM_OpCode),
        .address    (address),
        .data_in    (data_in),
        .data_out   (data_out),
        .MFC        (MFC),
        .mem_fault  (mem_fault),
        .o_dbg_state(dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Driver: one full transaction; the scoreboard entry is pushed on drive and popped at MFC.
    task automatic do_txn(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_data, input logic exp_fault, input int hold);
        int n;
        bit seen;
        logic [31:0] e_d;
        logic        e_f;
        @(negedge clk);
        RAM_OpCode = op;
        address    = addr;
        data_in    = wdata;
        RAM_enable = 1'b1;
        exp_q.push_back(exp_data);
        expf_q.push_back(exp_fault);
        @(posedge clk);
        #1;
        RAM_OpCode = 6'($urandom_range(0, 63));
        address    = $urandom;
        data_in    = $urandom;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (MFC) seen = 1'b1;
        end
        check("latency", 32'(n), 32'(WS + 1));
        e_d = exp_q.pop_front();
        e_f = expf_q.pop_front();
        check("data_out", data_out, e_d);
        check("mem_fault", 32'(mem_fault), 32'(e_f));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check("hold_mfc", 32'(MFC), 32'(1));
            check("hold_data", data_out, e_d);
        end
        @(negedge clk);
        RAM_enable = 1'b0;
        @(posedge clk);
        #1;
        check("release_mfc", 32'(MFC), 32'(0));
        check("release_fault", 32'(mem_fault), 32'(0));
    endtask

    initial begin
        vecs[0]  = '{OP_ST,   32'h0000_0010, 32'hDEADBEEF, 32'h0000_0000, 1'b0};
        vecs[1]  = '{OP_LD,   32'h0000_0010, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{OP_LDUB, 32'h0000_0011, 32'h0,        32'h0000_00AD, 1'b0};
        vecs[3]  = '{OP_LDSB, 32'h0000_0010, 32'h0,        32'hFFFF_FFDE, 1'b0};
        vecs[4]  = '{OP_STH,  32'h0000_0022, 32'h0000_8001, 32'hFFFF_FFDE, 1'b0};
        vecs[5]  = '{OP_LDUH, 32'h0000_0022, 32'h0,        32'h0000_8001, 1'b0};
        vecs[6]  = '{OP_LDSH, 32'h0000_0022, 32'h0,        32'hFFFF_8001, 1'b0};
        vecs[7]  = '{OP_STB,  32'h0000_0013, 32'h0000_005A, 32'hFFFF_8001, 1'b0};
        vecs[8]  = '{OP_LD,   32'h0000_0010, 32'h0,        32'hDEADBE5A, 1'b0};
        vecs[9]  = '{OP_LD,   32'h0000_0002, 32'h0,        32'hDEADBE5A, 1'b1};
        vecs[10] = '{OP_ST,   32'h0000_0011, 32'h1234_5678, 32'hDEADBE5A, 1'b1};
        vecs[11] = '{OP_LD,   32'h0000_0010, 32'h0,        32'hDEADBE5A, 1'b0};
        vecs[12] = '{OP_BAD,  32'h0000_0010, 32'h0,        32'hDEADBE5A, 1'b1};
        vecs[13] = '{OP_ST,   32'h0000_0214, 32'hCAFEF00D, 32'hDEADBE5A, 1'b0};
        vecs[14] = '{OP_LD,   32'h0000_0014, 32'h0,        32'hCAFEF00D, 1'b0};
        vecs[15] = '{OP_LD,   32'h0000_0210, 32'h0,        32'hDEADBE5A, 1'b0};
        vecs[16] = '{OP_LDUH, 32'h0000_0011, 32'h0,        32'hDEADBE5A, 1'b1};
        vecs[17] = '{OP_STH,  32'h0000_0021, 32'h0000_BEEF, 32'hDEADBE5A, 1'b1};
        vecs[18] = '{OP_LDUB, 32'h0000_0023, 32'h0,        32'h0000_0001, 1'b0};
        vecs[19] = '{OP_LDSB, 32'h0000_0012, 32'h0,        32'hFFFF_FFBE, 1'b0};
        vecs[20] = '{OP_LDSB, 32'h0000_0017, 32'h0,        32'h0000_000D, 1'b0};
        vecs[21] = '{OP_ST,   32'h0000_0030, 32'h1234_5678, 32'h0000_000D, 1'b0};
        vecs[22] = '{OP_LD,   32'h0000_0030, 32'h0,        32'h1234_5678, 1'b0};

        clr        = 1'b0;
        RAM_enable = 1'b0;
        RAM_OpCode = '0;
        address    = '0;
        data_in    = '0;
        repeat (3) @(negedge clk);
        check("reset_mfc", 32'(MFC), 32'(0));
        check("reset_fault", 32'(mem_fault), 32'(0));
        check("reset_data", data_out, 32'h0);
        clr = 1'b1;
        repeat (2) @(negedge clk);
        check("post_reset_mfc", 32'(MFC), 32'(0));
        check("post_reset_data", data_out, 32'h0);

        for (int i = 0; i < NV; i++) begin
            do_txn(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].exp_data, vecs[i].exp_fault, 0);
        end

        // Abort: drop RAM_enable during WAIT of a store
        @(negedge clk);
        RAM_OpCode = OP_ST;
        address    = 32'h0000_0030;
        data_in    = 32'h1111_1111;
        RAM_enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        RAM_enable = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("abort_mfc", 32'(MFC), 32'(0));
        end
        check("abort_data", data_out, 32'h1234_5678);
        do_txn(OP_LD, 32'h0000_0030, 32'h0, 32'h1234_5678, 1'b0, 0);

        // Reset pulsed mid-WAIT of a store
        @(negedge clk);
        RAM_OpCode = OP_ST;
        address    = 32'h0000_0030;
        data_in    = 32'h1111_1111;
        RAM_enable = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        clr = 1'b0;
        #1;
        check("midreset_mfc", 32'(MFC), 32'(0));
        check("midreset_data", data_out, 32'h0);
        RAM_enable = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            check("midreset_idle_mfc", 32'(MFC), 32'(0));
        end
        do_txn(OP_LD, 32'h0000_0030, 32'h0, 32'h1234_5678, 1'b0, 0);

        // Handshake: hold RAM_enable five cycles after MFC, then release and re-raise
        do_txn(OP_LD, 32'h0000_0010, 32'h0, 32'hDEADBE5A, 1'b0, 5);
        do_txn(OP_LD, 32'h0000_0014, 32'h0, 32'hCAFEF00D, 1'b0, 0);

        // Held store: a long hold must not write twice or change anything
        do_txn(OP_STB, 32'h0000_0031, 32'h0000_0099, 32'hCAFEF00D, 1'b0, 5);
        do_txn(OP_LD, 32'h0000_0030, 32'h0, 32'h1299_5678, 1'b0, 0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/memory_responder.md
# memory_responder

Byte-addressed data memory that answers the control unit's load/store requests over the MAR/MDR/RAM_OpCode/MFC handshake. It latches a request and inserts a programmable number of wait states. It then performs a SPARC V8 big-endian load or store of byte, halfword or word size, and raises MFC until the control unit drops RAM_enable. It sits behind MAR and MDR. Its read data feeds the MDR input mux.

## Interface

- ADDR_WIDTH, 9: log2 of memory size in bytes (512 B).
- WAIT_STATES, 2: idle cycles inserted between request latch and access (0 allowed).

Ports:

- clk  in  1  sole clock; everything samples on the rising edge.
- clr  in  1  asynchronous, active-low reset.
- RAM_enable  in  1  request strobe from the control unit; level-held for the whole transaction.
- RAM_OpCode  in  6  SPARC op3 of the memory instruction.
- address  in  32  byte address from MAR.
- data_in  in  32  store data from MDR; the right-justified byte or halfword is used for stb/sth.
- data_out  out  32  load result, zero- or sign-extended to 32 bits.
- MFC  out  1  memory function complete.
- mem_fault  out  1  request rejected because of misalignment or an unsupported opcode; valid while MFC=1.

## Operation

- Storage: 2^ADDR_WIDTH bytes, big-endian.
  - Word at A: mem[A]=bits 31:24 … mem[A+3]=bits 7:0.
  - Effective address = address[ADDR_WIDTH-1:0]; upper bits are ignored, so addresses wrap.
  - Contents are not cleared by reset.
- Opcodes:
  - 000000 ld (word).
  - 000001 ldub.
  - 000010 lduh.
  - 001001 ldsb.
  - 001010 ldsh.
  - 000100 st (word).
  - 000101 stb.
  - 000110 sth.
  - Any other opcode leads to a fault.
- Alignment: word requests need address[1:0]=00; halfword requests need address[0]=0. A misaligned request faults.
- A fault:
  - completes the handshake normally, with MFC=1 and mem_fault=1;
  - leaves memory unwritten;
  - leaves data_out unchanged.
- States: IDLE, WAIT, ACCESS, DONE.
  - IDLE: if RAM_enable=1, latch opcode, address and data_in. Load cnt=WAIT_STATES. Go to WAIT if WAIT_STATES>0, else go to ACCESS.
  - WAIT: if RAM_enable=0, abort to IDLE with no access and no MFC. Otherwise decrement cnt and go to ACCESS when cnt reaches 1.
  - ACCESS: if RAM_enable=0, abort to IDLE. Otherwise:
    - perform the write, or register the read into data_out;
    - set mem_fault from the decode;
    - set MFC=1;
    - go to DONE.
  - DONE: hold MFC, data_out and mem_fault. When RAM_enable=0, clear MFC and mem_fault and go to IDLE.
- Inputs that change after the latch edge do not affect the transaction in flight.
- A new request is accepted only when RAM_enable is sampled high in IDLE. This requires at least one low sample between transactions. Holding RAM_enable high in DONE never starts a second access.

## Timing

- Reset (clr=0, asynchronous): state=IDLE, cnt=0, MFC=0, mem_fault=0, data_out=0x00000000.
- Latency: let edge 0 be the IDLE edge that samples RAM_enable=1.
  - The access occurs at edge WAIT_STATES+1.
  - MFC, data_out and mem_fault are registered at that same edge. They are valid together, with no combinational path from the inputs.
- Release: RAM_enable low sampled in DONE at edge k gives MFC=0 after edge k. The earliest next latch is edge k+1.
- Abort: RAM_enable low at any edge before the access returns to IDLE. No write occurs, MFC stays 0, and data_out is unchanged.
- Reset mid-transaction: the transaction is abandoned. A store not yet at its ACCESS edge never writes.
- Stores write all affected bytes in the single ACCESS edge.

## Test plan

- Reset, then release clr with RAM_enable=0 -> MFC=0, mem_fault=0, data_out=0. With WAIT_STATES=2, raise RAM_enable -> MFC rises exactly 3 edges after the latch edge.
- Word: st 0xDEADBEEF @0x010, then ld @0x010 -> 0xDEADBEEF. ldub @0x011 -> 0x000000AD. ldsb @0x010 -> 0xFFFFFFDE.
- Partial stores:
  - sth 0x00008001 @0x022, then lduh @0x022 -> 0x00008001 and ldsh -> 0xFFFF8001.
  - stb 0x0000005A @0x013, then ld @0x010 -> 0xDEADBE5A.
- Faults:
  - ld @0x002 -> MFC=1, mem_fault=1, data_out unchanged.
  - st @0x011 -> fault, and a later ld @0x010 is unchanged.
  - Opcode 111111 -> fault.
  - Address 0x00000210 aliases 0x010.
- Abort and reset: drop RAM_enable during WAIT of st 0x11111111 @0x030 -> no MFC and mem @0x030 unchanged. Repeat with clr pulsed low mid-WAIT -> same result.
- Handshake: hold RAM_enable high 5 cycles after MFC -> MFC stays 1 and only one access occurs. Drop RAM_enable -> MFC=0 after the next edge. Re-raise -> a new transaction completes with identical latency.
